rpn_exec: RTL and testbench

- Token executor for the RPN calculator, sitting between the token source (keypad/UART parser) and the operand stack.
- Number tokens are pushed onto the stack.
- Operator tokens pop two operands, compute the result, and push it back.
- '=' pops the top of stack and presents it on the result port. Faults are reported as a sticky error code.

---
 rtl/rpn_exec.sv | 145 ++++++++++++++
 tb/tb_rpn_exec.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_exec.sv
// rpn_exec: RPN token executor; pushes numbers, pops/combines operands, reports '=' results.
// Define RPN_MUL_EN to accept '*' (0x2A) as a binary operator.
module rpn_exec #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tok_stb_i,
    input  logic          tok_op_i,
    input  logic [DW-1:0] tok_dat_i,
    output logic          tok_ack_o,
    output logic          push_stb_o,
    output logic [DW-1:0] push_dat_o,
    input  logic          push_ack_i,
    input  logic          pop_stb_i,
    input  logic [DW-1:0] pop_dat_i,
    output logic          pop_ack_o,
    output logic          res_stb_o,
    output logic [DW-1:0] res_dat_o,
    output logic [1:0]    err_code_o,
    input  logic          clr_stb_i
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PUSH  = 4'd1;
    localparam logic [3:0] S_PWAIT = 4'd2;
    localparam logic [3:0] S_POPB  = 4'd3;
    localparam logic [3:0] S_GAPB  = 4'd4;
    localparam logic [3:0] S_POPA  = 4'd5;
    localparam logic [3:0] S_GAPA  = 4'd6;
    localparam logic [3:0] S_EXEC  = 4'd7;
    localparam logic [3:0] S_POPR  = 4'd8;
    localparam logic [3:0] S_GAPR  = 4'd9;
    localparam logic [3:0] S_ACK   = 4'd10;
    localparam logic [3:0] S_ERR   = 4'd11;
    localparam logic [DW-1:0] OP_ADD = DW'(8'h2B);
    localparam logic [DW-1:0] OP_SUB = DW'(8'h2D);
    localparam logic [DW-1:0] OP_EQ  = DW'(8'h3D);

    logic [3:0]    state_q, state_d;
    logic [DW-1:0] op_q, op_d, a_q, a_d, b_q, b_d;
    logic [DW-1:0] push_dat_q, push_dat_d, res_dat_q, res_dat_d, alu_r;
    logic [1:0]    err_q, err_d;
    logic          ent_q, ent_d, bin_op;

`ifdef RPN_MUL_EN
    localparam logic [DW-1:0] OP_MUL = DW'(8'h2A);
    assign bin_op = (tok_dat_i == OP_ADD) || (tok_dat_i == OP_SUB) || (tok_dat_i == OP_MUL);
    assign alu_r  = (op_q == OP_MUL) ? a_q * b_q : (op_q == OP_SUB) ? a_q - b_q : a_q + b_q;
`else
    assign bin_op = (tok_dat_i == OP_ADD) || (tok_dat_i == OP_SUB);
    assign alu_r  = (op_q == OP_SUB) ? a_q - b_q : a_q + b_q;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        push_dat_d = push_dat_q;
        res_dat_d  = res_dat_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: if (tok_stb_i) begin
                op_d = tok_dat_i;
                if (!tok_op_i) begin
                    push_dat_d = tok_dat_i;
                    state_d    = S_PUSH;
                end else if (bin_op) begin
                    state_d = S_POPB;
                end else if (tok_dat_i == OP_EQ) begin
                    state_d = S_POPR;
                end else begin
                    state_d = S_ERR;
                    err_d   = 2'd3;
                end
            end
            S_PUSH:  state_d = S_PWAIT;
            S_PWAIT: begin
                state_d = push_ack_i ? S_ACK : S_ERR;
                err_d   = push_ack_i ? err_q : 2'd2;
            end
            S_POPB: begin
                b_d     = pop_stb_i ? pop_dat_i : b_q;
                state_d = pop_stb_i ? S_GAPB : S_ERR;
                err_d   = pop_stb_i ? err_q : 2'd1;
            end
            S_GAPB:  state_d = S_POPA;
            // An underflow here discards the already-popped B operand.
            S_POPA: begin
                a_d     = pop_stb_i ? pop_dat_i : a_q;
                state_d = pop_stb_i ? S_GAPA : S_ERR;
                err_d   = pop_stb_i ? err_q : 2'd1;
            end
            S_GAPA:  state_d = S_EXEC;
            S_EXEC: begin
                push_dat_d = alu_r;
                state_d    = S_PUSH;
            end
            S_POPR: begin
                res_dat_d = pop_stb_i ? pop_dat_i : res_dat_q;
                state_d   = pop_stb_i ? S_GAPR : S_ERR;
                err_d     = pop_stb_i ? err_q : 2'd1;
            end
            S_GAPR:  state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            S_ERR: if (clr_stb_i) begin
                err_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ent_d = (state_d == S_ERR) && (state_q != S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            push_dat_q <= '0;
            res_dat_q  <= '0;
            err_q      <= 2'd0;
            ent_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            push_dat_q <= push_dat_d;
            res_dat_q  <= res_dat_d;
            err_q      <= err_d;
            ent_q      <= ent_d;
        end
    end

    assign tok_ack_o  = (state_q == S_ACK) || ent_q;
    assign push_stb_o = state_q == S_PUSH;
    assign push_dat_o = push_dat_q;
    assign pop_ack_o  = pop_stb_i && ((state_q == S_POPB) || (state_q == S_POPA) || (state_q == S_POPR));
    assign res_stb_o  = pop_stb_i && (state_q == S_POPR);
    assign res_dat_o  = res_dat_q;
    assign err_code_o = err_q;
endmodule

// File: tb/tb_rpn_exec.sv
// tb_rpn_exec: directed token sequences against a token-level stack model of rpn_exec.
module tb_rpn_exec;
    localparam logic [7:0] ADD = 8'h2B, SUB = 8'h2D, MUL = 8'h2A, EQ = 8'h3D;
`ifdef RPN_MUL_EN
    localparam bit MUL_OK = 1'b1;
`else
    localparam bit MUL_OK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tok_stb = 1'b0, tok_op = 1'b0, clr = 1'b0;
    logic [7:0] tok_dat = 8'h00;
    logic       push_ack = 1'b0, pop_stb = 1'b0;
    logic [7:0] pop_dat = 8'h00;
    logic       tok_ack, push_stb, pop_ack, res_stb;
    logic [7:0] push_dat, res_dat;
    logic [1:0] err_code;

    int checks = 0, failures = 0;
    int n_push = 0, n_pop = 0, n_res = 0;
    logic busy = 1'b0, prev_push = 1'b0, prev_pop = 1'b0;
    int m_stk[$];
    int m_err = 0, m_res = 0;
    logic [7:0] stk[$];
    logic [7:0] pend_dat = 8'h00;
    logic ppend = 1'b0, opend = 1'b0;

    always #5 clk = ~clk;

    rpn_exec #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .tok_stb_i(tok_stb), .tok_op_i(tok_op), .tok_dat_i(tok_dat), .tok_ack_o(tok_ack),
        .push_stb_o(push_stb), .push_dat_o(push_dat), .push_ack_i(push_ack),
        .pop_stb_i(pop_stb), .pop_dat_i(pop_dat), .pop_ack_o(pop_ack),
        .res_stb_o(res_stb), .res_dat_o(res_dat), .err_code_o(err_code), .clr_stb_i(clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 16-entry stack: acks a push one cycle after PUSH_STB, retires a pop one cycle after POP_ACK
    always @(negedge clk) begin
        if (!rst_n) begin
            ppend = 1'b0;
            opend = 1'b0;
            push_ack = 1'b0;
        end else begin
            push_ack = 1'b0;
            if (ppend && stk.size() < 16) begin
                stk.push_back(pend_dat);
                push_ack = 1'b1;
            end
            if (opend && stk.size() > 0) void'(stk.pop_back());
            ppend = push_stb;
            pend_dat = push_dat;
            opend = pop_ack;
        end
        pop_stb = stk.size() > 0;
        pop_dat = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_push = 1'b0;
            prev_pop = 1'b0;
        end else begin
            chk("strobe_rules", {push_stb && pop_ack, push_stb && prev_push, pop_ack && prev_pop, pop_ack && !pop_stb}, 0);
            n_push += int'(push_stb);
            n_pop += int'(pop_ack);
            n_res += int'(res_stb);
            prev_push = push_stb;
            prev_pop = pop_ack;
            if (!busy) begin
                chk("idle_quiet", {tok_ack, push_stb, pop_ack, res_stb}, 0);
                chk("idle_err", err_code, m_err);
                chk("idle_res", res_dat, m_res);
            end
        end
    end

    task automatic tok(input logic op, input logic [7:0] d);
        int e_lat, e_push, e_pop, e_res, cyc, p0, q0, r0, a, b;
        logic e_ack, got;
        @(negedge clk);
        busy = 1'b1;
        e_ack = (m_err == 0);
        e_lat = 0; e_push = 0; e_pop = 0; e_res = 0;
        if (m_err == 0) begin
            if (!op) begin
                e_push = 1;
                if (m_stk.size() == 16) m_err = 2;
                else begin
                    m_stk.push_back(int'(d));
                    e_lat = 3;
                end
            end else if (d == ADD || d == SUB || (MUL_OK && d == MUL)) begin
                if (m_stk.size() < 2) begin
                    e_pop = m_stk.size();
                    m_stk.delete();
                    m_err = 1;
                end else begin
                    b = m_stk.pop_back();
                    a = m_stk.pop_back();
                    m_stk.push_back(((d == ADD) ? a + b : (d == SUB) ? a - b : a * b) & 255);
                    e_pop = 2; e_push = 1; e_lat = 8;
                end
            end else if (d == EQ) begin
                if (m_stk.size() == 0) m_err = 1;
                else begin
                    m_res = m_stk.pop_back();
                    e_pop = 1; e_res = 1; e_lat = 3;
                end
            end else m_err = 3;
        end
        p0 = n_push; q0 = n_pop; r0 = n_res;
        tok_op = op; tok_dat = d; tok_stb = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < (e_ack ? 20 : 6)) begin
            @(negedge clk);
            cyc++;
            got = tok_ack;
        end
        tok_stb = 1'b0;
        chk("tok_ack", got, e_ack);
        if (e_lat != 0) chk("latency", cyc, e_lat);
        chk("err_code", err_code, m_err);
        chk("pushes", n_push - p0, e_push);
        chk("pops", n_pop - q0, e_pop);
        chk("res_pulses", n_res - r0, e_res);
        if (e_res != 0) chk("res_dat", res_dat, m_res);
        @(negedge clk);
        busy = 1'b0;
    endtask

    task automatic do_clr;
        @(negedge clk);
        busy = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_err = 0;
        chk("clr_err", err_code, 0);
        @(negedge clk);
        busy = 1'b0;
    endtask

    task automatic drain;
        while (m_stk.size() > 0) tok(1'b1, EQ);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_tok_ack"}, tok_ack, 0);
        chk({tag, "_push_stb"}, push_stb, 0);
        chk({tag, "_pop_ack"}, pop_ack, 0);
        chk({tag, "_res_stb"}, res_stb, 0);
        chk({tag, "_push_dat"}, push_dat, 0);
        chk({tag, "_res_dat"}, res_dat, 0);
        chk({tag, "_err"}, err_code, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, q0, cyc;
        busy = 1'b1;
        repeat (2) @(negedge clk);
        rst_chk("reset");
        #2 rst_n = 1'b1;
        busy = 1'b0;

        p0 = n_push; q0 = n_pop;
        tok(1'b0, 8'd3); tok(1'b0, 8'd4); tok(1'b1, ADD); tok(1'b1, EQ);
        chk("lit_add", res_dat, 8'h07);
        chk("lit_add_err", err_code, 0);
        chk("lit_add_pushes", n_push - p0, 3);
        chk("lit_add_pops", n_pop - q0, 3);

        tok(1'b0, 8'd3); tok(1'b0, 8'd5); tok(1'b1, SUB); tok(1'b1, EQ);
        chk("lit_sub", res_dat, 8'hFE);
        tok(1'b0, 8'hFF); tok(1'b0, 8'h01); tok(1'b1, ADD); tok(1'b1, EQ);
        chk("lit_wrap", res_dat, 8'h00);

        tok(1'b0, 8'd6); tok(1'b0, 8'd7); tok(1'b1, MUL); tok(1'b1, EQ);
`ifdef RPN_MUL_EN
        chk("lit_mul", res_dat, 8'h2A);
`else
        chk("lit_mul_illegal", err_code, 3);
        do_clr();
`endif
        drain();

        tok(1'b0, 8'd9); tok(1'b1, ADD);
        chk("lit_underflow", err_code, 1);
        tok(1'b0, 8'd5);
        tok(1'b1, EQ);
        chk("lit_ignored_err", err_code, 1);
        do_clr();
        tok(1'b0, 8'd2); tok(1'b1, EQ);
        chk("lit_after_clr", res_dat, 8'h02);

        for (int i = 1; i <= 16; i++) tok(1'b0, 8'(i));
        tok(1'b0, 8'd17);
        chk("lit_overflow", err_code, 2);
        do_clr();
        drain();
        chk("lit_drain_last", res_dat, 8'h01);

        tok(1'b1, 8'h41);
        chk("lit_illegal", err_code, 3);
        do_clr();

        @(negedge clk);
        busy = 1'b1;
        tok_op = 1'b0; tok_dat = 8'h55; tok_stb = 1'b1;
        cyc = 0;
        while (!push_stb && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_push", push_stb, 1);
        chk("rst_push_dat", push_dat, 8'h55);
        @(posedge clk);
        #2 rst_n = 1'b0;
        m_res = 0;
        #1 tok_stb = 1'b0;
        rst_chk("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        busy = 1'b0;
        tok(1'b0, 8'd1); tok(1'b1, EQ);
        chk("lit_post_reset", res_dat, 8'h01);
        chk("lit_post_reset_empty", stk.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
